// File: rtl/adder_result_stage.sv
// Registered result stage behind the CLA adder: a 2-entry FIFO
// with a sticky signed-overflow flag and an accepted-result counter.
module adder_result_stage #(
  parameter int WIDTH     = 32,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH:0]       in_result,
  input  logic                 in_overflow,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH:0]       out_result,
  output logic                 out_overflow,
  input  logic                 ovf_clear,
  output logic                 ovf_sticky,
  output logic [CNT_WIDTH-1:0] result_count
);

  typedef struct packed {
    logic           ovf;
    logic [WIDTH:0] res;
  } entry_t;

  entry_t     head_q;
  entry_t     tail_q;
  entry_t     in_e;
  logic [1:0] occ_q;
  logic [1:0] occ_d;
  logic       push;
  logic       pop;

  assign in_ready  = (occ_q != 2'd2);
  assign out_valid = (occ_q != 2'd0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  assign in_e.ovf = in_overflow;
  assign in_e.res = in_result;

  // Head reads zero when empty so stale entries never leak out.
  assign out_result   = out_valid ? head_q.res : '0;
  assign out_overflow = out_valid & head_q.ovf;

  always_comb begin
    occ_d = occ_q;
    unique case (1'b1)
      (push && !pop): occ_d = occ_q + 2'd1;
      (pop && !push): occ_d = occ_q - 2'd1;
      default:        occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q  <= 2'd0;
      head_q <= '0;
      tail_q <= '0;
    end else begin
      occ_q <= occ_d;
      if (push && (occ_q == 2'd0 || pop))
        head_q <= in_e;
      else if (pop)
        head_q <= tail_q;
      if (push && !pop && occ_q == 2'd1)
        tail_q <= in_e;
    end
  end

  // A push with overflow wins over a same-edge clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_sticky   <= 1'b0;
      result_count <= '0;
    end else begin
      if (push && in_overflow)
        ovf_sticky <= 1'b1;
      else if (ovf_clear)
        ovf_sticky <= 1'b0;
      if (push)
        result_count <= result_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_adder_result_stage.sv
// Scoreboard bench for adder_result_stage (WIDTH=8, CNT_WIDTH=8).
// A model queue tracks FIFO contents; outputs are checked each negedge.
module tb_adder_result_stage;

  localparam int W  = 8;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W:0]    in_result;
  logic          in_overflow;
  logic          out_valid;
  logic          out_ready;
  logic [W:0]    out_result;
  logic          out_overflow;
  logic          ovf_clear;
  logic          ovf_sticky;
  logic [CW-1:0] result_count;

  adder_result_stage #(.WIDTH(W), .CNT_WIDTH(CW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_result    (in_result),
    .in_overflow  (in_overflow),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_result   (out_result),
    .out_overflow (out_overflow),
    .ovf_clear    (ovf_clear),
    .ovf_sticky   (ovf_sticky),
    .result_count (result_count)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic [W+1:0]  sb_q[$];
  logic          m_sticky;
  logic [CW-1:0] m_cnt;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               tag, got, exp, $time);
    end
  endtask

  // Check outputs against the model, then advance the model by
  // the handshake that the coming posedge will perform.
  always @(negedge clk) begin
    if (rst_n) begin
      logic [W+1:0] hd;
      logic push_m;
      logic pop_m;
      hd = (sb_q.size() != 0) ? sb_q[0] : '0;
      chk("in_ready", 32'(in_ready), 32'(sb_q.size() != 2));
      chk("out_valid", 32'(out_valid), 32'(sb_q.size() != 0));
      chk("out_result", 32'(out_result), 32'(hd[W:0]));
      chk("out_ovf", 32'(out_overflow), 32'(hd[W+1]));
      chk("sticky", 32'(ovf_sticky), 32'(m_sticky));
      chk("count", 32'(result_count), 32'(m_cnt));
      push_m = in_valid && (sb_q.size() != 2);
      pop_m  = out_ready && (sb_q.size() != 0);
      if (pop_m) void'(sb_q.pop_front());
      if (push_m) begin
        sb_q.push_back({in_overflow, in_result});
        m_cnt = m_cnt + 1'b1;
      end
      if (push_m && in_overflow) m_sticky = 1'b1;
      else if (ovf_clear)        m_sticky = 1'b0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    sb_q.delete();
    m_sticky = 1'b0;
    m_cnt = '0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_result", 32'(out_result), 32'd0);
    chk("rst_sticky", 32'(ovf_sticky), 32'd0);
    chk("rst_count", 32'(result_count), 32'd0);
    step();
    rst_n = 1'b1;
  endtask

  task automatic drain();
    int n = 0;
    out_ready = 1'b1;
    in_valid = 1'b0;
    while (sb_q.size() != 0 && n < 20) begin
      step();
      n++;
    end
    chk("drain_timeout", 32'(sb_q.size()), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_result = '0;
    in_overflow = 1'b0;
    out_ready = 1'b0;
    ovf_clear = 1'b0;
    m_sticky = 1'b0;
    m_cnt = '0;
    #12;
    do_reset();
    repeat (3) step();

    // single push, pop on the following edge
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_result = 9'h1FE;
    step();
    in_valid = 1'b0;
    chk("t2_valid", 32'(out_valid), 32'd1);
    chk("t2_data", 32'(out_result), 32'h1FE);
    step();
    chk("t2_popped", 32'(out_valid), 32'd0);
    chk("t2_count", 32'(result_count), 32'd1);

    // fill with consumer stalled; third value must wait
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_result = 9'h001;
    step();
    in_result = 9'h002;
    step();
    chk("t3_full", 32'(in_ready), 32'd0);
    in_result = 9'h003;
    repeat (3) step();
    chk("t3_hold", 32'(out_result), 32'h001);
    out_ready = 1'b1;
    step();
    chk("t3_second", 32'(out_result), 32'h002);
    step();
    in_valid = 1'b0;
    chk("t3_third", 32'(out_result), 32'h003);
    drain();

    // mid-operation reset with two entries buffered
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_result = 9'h055;
    in_overflow = 1'b1;
    repeat (2) step();
    in_valid = 1'b0;
    in_overflow = 1'b0;
    chk("t1_full", 32'(in_ready), 32'd0);
    do_reset();
    step();

    // 256 back-to-back pushes; 8-bit counter returns to zero
    out_ready = 1'b1;
    for (int i = 0; i < 256; i++) begin
      in_valid = 1'b1;
      in_result = 9'(($urandom_range(0, 1) << 8) | i);
      step();
    end
    in_valid = 1'b0;
    chk("t4_wrap", 32'(result_count), 32'd0);
    drain();

    // overflow entry and sticky behaviour
    in_valid = 1'b1;
    in_overflow = 1'b1;
    in_result = 9'h080;
    step();
    in_valid = 1'b0;
    in_overflow = 1'b0;
    chk("t5_ovf", 32'(out_overflow), 32'd1);
    chk("t5_sticky", 32'(ovf_sticky), 32'd1);
    ovf_clear = 1'b1;
    step();
    ovf_clear = 1'b0;
    chk("t5_clear", 32'(ovf_sticky), 32'd0);
    ovf_clear = 1'b1;
    in_valid = 1'b1;
    in_overflow = 1'b1;
    in_result = 9'h081;
    step();
    ovf_clear = 1'b0;
    in_valid = 1'b0;
    in_overflow = 1'b0;
    chk("t5_set_wins", 32'(ovf_sticky), 32'd1);

    // random traffic with random consumer stalls
    for (int i = 0; i < 200; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_result = 9'($urandom_range(0, 511));
      in_overflow = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      ovf_clear = 1'($urandom_range(0, 3) == 0);
      step();
    end
    ovf_clear = 1'b0;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
